// File: rtl/fetch_queue_if.sv
// Bundles the fetch front end's memory, pipeline-control and head-of-queue signals.
// master is the fetch queue itself; slave is the surrounding pipeline and memory.
interface fetch_queue_if #(
  parameter int unsigned CW = 3
) ();
  logic [31:0]   imem_addr;
  logic [31:0]   imem_inst;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          stall;
  logic          out_valid;
  logic [31:0]   out_inst;
  logic [31:0]   out_pcnew;
  logic [CW-1:0] count;

  modport master (
    output imem_addr,
    output out_valid,
    output out_inst,
    output out_pcnew,
    output count,
    input  imem_inst,
    input  redirect,
    input  redirect_pc,
    input  stall
  );

  modport slave (
    input  imem_addr,
    input  out_valid,
    input  out_inst,
    input  out_pcnew,
    input  count,
    output imem_inst,
    output redirect,
    output redirect_pc,
    output stall
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC and buffers each fetched instruction with its
// PC+4 in a small circular FIFO, so ID stalls no longer freeze fetch.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CW       = $clog2(DEPTH) + 1
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int unsigned   PW        = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [31:0]   instMem  [DEPTH];
  logic [31:0]   pcNewMem [DEPTH];
  logic [31:0]   fetchPc;
  logic [31:0]   fetchPcNext;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] occupancy;
  logic          headValid;
  logic          isFull;
  logic          pop;
  logic          push;

  always_comb begin
    headValid   = (occupancy != '0);
    isFull      = (occupancy == FullCount);
    pop         = headValid && !bus.stall && !bus.redirect;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    push        = !bus.redirect && (!isFull || pop);
    fetchPcNext = fetchPc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc   <= RESET_PC;
      rdPtr     <= '0;
      wrPtr     <= '0;
      occupancy <= '0;
    end else if (bus.redirect) begin
      fetchPc   <= bus.redirect_pc;
      rdPtr     <= '0;
      wrPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wrPtr   <= wrPtr + PW'(1);
        fetchPc <= fetchPcNext;
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      if (push && !pop) begin
        occupancy <= occupancy + CW'(1);
      end else if (pop && !push) begin
        occupancy <= occupancy - CW'(1);
      end
    end
  end

  // Storage carries no reset; only entries between rdPtr and wrPtr are ever observed.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instMem[wrPtr]  <= bus.imem_inst;
      pcNewMem[wrPtr] <= fetchPcNext;
    end
  end

  always_comb begin
    bus.imem_addr = fetchPc;
    bus.count     = occupancy;
    bus.out_valid = headValid;
    bus.out_inst  = headValid ? instMem[rdPtr] : 32'h0;
    bus.out_pcnew = headValid ? pcNewMem[rdPtr] : 32'h0;
  end

  assert property (@(posedge clk) disable iff (reset) occupancy <= FullCount);
  assert property (@(posedge clk) disable iff (reset) (pop && !push) |-> occupancy != '0);
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: a queue-based reference model predicts each fetched entry,
// and a separate monitor pops and compares whenever the DUT hands an entry to ID.
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] Salt     = 32'hA5A5_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_queue_if #(.CW(3)) bus ();

  fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .CW      (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_inst = bus.imem_addr ^ Salt;

  int          nCmp   = 0;
  int          nBad   = 0;
  logic [63:0] expQ[$];
  logic [31:0] mPc    = 32'h0;
  bit          mValid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every entry consumed by ID must be the oldest predicted fetch.
  always @(negedge clk) begin
    #2;
    if (mValid && !reset && bus.out_valid === 1'b1 && !bus.stall && !bus.redirect) begin
      if (expQ.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL unexpected_out: got pcnew %h, want no entry (t=%0t)", bus.out_pcnew, $time);
      end else begin
        logic [63:0] e;
        e = expQ.pop_front();
        chk("head_inst", bus.out_inst, e[63:32]);
        chk("head_pcnew", bus.out_pcnew, e[31:0]);
      end
    end
  end

  task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
    int sz;
    bit mPop;
    bit mPush;
    @(negedge clk);
    reset           = r;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.stall       = st;
    #1;
    sz = expQ.size();
    if (mValid) begin
      chk("imem_addr", bus.imem_addr, mPc);
      chk("count", 32'(bus.count), 32'(sz));
      chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
      if (sz == 0) begin
        chk("empty_inst", bus.out_inst, 32'h0);
        chk("empty_pcnew", bus.out_pcnew, 32'h0);
      end
    end
    mPop  = (sz != 0) && !st && !rd;
    mPush = !rd && ((sz < int'(DEPTH)) || mPop);
    @(posedge clk);
    if (r) begin
      expQ.delete();
      mPc    = RESET_PC;
      mValid = 1'b1;
    end else if (mValid) begin
      if (rd) begin
        expQ.delete();
        mPc = rpc;
      end else if (mPush) begin
        expQ.push_back({mPc ^ Salt, mPc + 32'd4});
        mPc = mPc + 32'd4;
      end
    end
  endtask

  initial begin
    logic [2:0]  stallCnt [6];
    logic [31:0] rpc;
    stallCnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.stall       = 1'b0;

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    #1;
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_addr", bus.imem_addr, RESET_PC);

    // Free run: first fetch visible one cycle later, then one in / one out.
    cycle(0, 0, 0, 0);
    #1;
    chk("first_inst", bus.out_inst, 32'hA5A5_0000);
    chk("first_pcnew", bus.out_pcnew, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      #1;
      chk("run_pcnew", bus.out_pcnew, 32'(8 + 4 * i));
      chk("run_count", 32'(bus.count), 32'h1);
    end

    // Stall from reset fills the queue, then fetch holds at 16.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 1);
      #1;
      chk("stall_count", 32'(bus.count), 32'(stallCnt[i]));
    end
    chk("stall_addr", bus.imem_addr, 32'h10);
    cycle(0, 0, 0, 0);
    #1;
    chk("fullpop_count", 32'(bus.count), 32'h4);
    chk("fullpop_addr", bus.imem_addr, 32'h14);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // Redirect with three entries queued.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h100, 0);
    #1;
    chk("redir_count", 32'(bus.count), 32'h0);
    chk("redir_valid", 32'(bus.out_valid), 32'h0);
    chk("redir_inst", bus.out_inst, 32'h0);
    chk("redir_addr", bus.imem_addr, 32'h100);
    cycle(0, 0, 0, 0);
    #1;
    chk("redir_pcnew", bus.out_pcnew, 32'h104);

    // Redirect wins over a simultaneous stall.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h300, 1);
    #1;
    chk("redstall_count", 32'(bus.count), 32'h0);
    chk("redstall_addr", bus.imem_addr, 32'h300);

    // Reset wins over a simultaneous redirect.
    cycle(0, 0, 0, 0);
    cycle(1, 1, 32'h200, 0);
    #1;
    chk("rstred_addr", bus.imem_addr, RESET_PC);
    chk("rstred_count", 32'(bus.count), 32'h0);

    // PC wraps from the top of the address space.
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 0);
    #1;
    chk("wrap_pcnew", bus.out_pcnew, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFFC;
        1:       rpc = $urandom();
        default: rpc = $urandom() & 32'h0000_FFFC;
      endcase
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0), rpc,
            ($urandom_range(0, 1) == 1));
    end
    cycle(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
